sd_sector_buffer: RTL

- 512-byte sector buffer that sits directly downstream of sd_card_mem.
- Services sd_card_mem's memory requests (o_req / o_wr_nrd / o_addr / o_data) over a four-phase req/ack handshake and returns read bytes to its i_data input.
- Exposes a byte-stream host port so the PS/2-VGA side can fill a sector before an SD write, or drain it after an SD read.
- Both sides share one single-port RAM; the SD side has priority.

---
 rtl/sd_buf_pkg.sv | 18 +
 rtl/sd_buf_ram.sv | 29 ++
 rtl/sd_sector_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sd_buf_pkg.sv
// Shared constants, SD-side FSM encoding and parity helper for the sector buffer.
package sd_buf_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int LAST_ADDR    = SECTOR_BYTES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ACK  = 2'd2
    } sd_state_e;

    // Even parity over a zero-extended word: returns the bit that makes the total even.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sd_buf_ram.sv
// Single-port synchronous RAM, one-cycle read latency; read register only updates on reads.
module sd_buf_ram #(
    parameter int ADDR_W = 9,
    parameter int W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer between sd_card_mem (four-phase req/ack) and a byte-stream host port.
// Define SD_SECTOR_BUFFER_PARITY_EN to store and check even parity on every RAM byte.
module sd_sector_buffer
    import sd_buf_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sd_req,
    input  logic              i_sd_wr_nrd,
    input  logic [ADDR_W-1:0] i_sd_addr,
    input  logic [DATA_W-1:0] i_sd_data,
    output logic [DATA_W-1:0] o_sd_data,
    output logic              o_sd_ack,
    input  logic              i_host_we,
    input  logic              i_host_re,
    input  logic [DATA_W-1:0] i_host_data,
    output logic [DATA_W-1:0] o_host_data,
    output logic              o_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_rewind,
    output logic [ADDR_W-1:0] o_host_ptr,
    output logic              o_sector_done,
    output logic              o_parity_err
);

`ifdef SD_SECTOR_BUFFER_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_A = '1;

    sd_state_e         state;
    logic [ADDR_W-1:0] sd_addr_q;
    logic [DATA_W-1:0] sd_data_q;
    logic              sd_wr_q;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] wr_byte;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic              host_wr, host_rd;

    // SD owns the port only in S_ACC; host is accepted only in S_IDLE, so they never collide.
    assign o_host_ready = i_rst_n && (state == S_IDLE) && !i_sd_req;
    assign host_wr      = o_host_ready && i_host_we && !i_host_rewind;
    assign host_rd      = o_host_ready && i_host_re && !i_host_we && !i_host_rewind;
    assign o_host_data  = ram_rdata[DATA_W-1:0];

    always_comb begin
        ram_en   = host_wr || host_rd;
        ram_we   = host_wr;
        ram_addr = o_host_ptr;
        wr_byte  = i_host_data;
        if (state == S_ACC) begin
            ram_en   = 1'b1;
            ram_we   = sd_wr_q;
            ram_addr = sd_addr_q;
            wr_byte  = sd_data_q;
        end
    end

`ifdef SD_SECTOR_BUFFER_PARITY_EN
    assign ram_wdata = {even_par(64'(wr_byte)), wr_byte};
`else
    assign ram_wdata = wr_byte;
`endif

    sd_buf_ram #(.ADDR_W(ADDR_W), .W(RAM_W)) u_ram (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            sd_addr_q     <= '0;
            sd_data_q     <= '0;
            sd_wr_q       <= 1'b0;
            o_sd_ack      <= 1'b0;
            o_sd_data     <= '0;
            o_host_valid  <= 1'b0;
            o_host_ptr    <= '0;
            o_sector_done <= 1'b0;
        end else begin
            o_host_valid <= host_rd;
            if (i_host_rewind) begin
                o_host_ptr    <= '0;
                o_sector_done <= 1'b0;
            end else if (host_wr || host_rd) begin
                o_host_ptr <= o_host_ptr + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_sd_req) begin
                        sd_addr_q <= i_sd_addr;
                        sd_data_q <= i_sd_data;
                        sd_wr_q   <= i_sd_wr_nrd;
                        state     <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (sd_addr_q == LAST_A)
                        o_sector_done <= 1'b1;
                    state <= S_ACK;
                end
                S_ACK: begin
                    // Ack always rises for one cycle, even if req was withdrawn early.
                    if (!o_sd_ack) begin
                        o_sd_ack  <= 1'b1;
                        o_sd_data <= ram_rdata[DATA_W-1:0];
                    end else if (!i_sd_req) begin
                        o_sd_ack <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SD_SECTOR_BUFFER_PARITY_EN
    logic sd_chk;
    assign sd_chk = (state == S_ACK) && !o_sd_ack && !sd_wr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_parity_err <= 1'b0;
        else if (i_host_rewind)
            o_parity_err <= 1'b0;
        else if ((sd_chk || o_host_valid) && even_par(64'(ram_rdata)))
            o_parity_err <= 1'b1;
    end
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
